// File: rtl/fib_seq_ctrl.sv
// Paced sequencer for the 16-bit Fibonacci datapath.
// Issues term requests at TICK_HZ, captures results and flags timeout/wrap.
module fib_seq_ctrl #(
  parameter int CLK_HZ      = 100_000_000,
  parameter int TICK_HZ     = 10,
  parameter int MAX_TERMS   = 24,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        pause,
  output logic        f_rst,
  output logic        f_en,
  input  logic        f_valid,
  input  logic [15:0] f_out,
  output logic [15:0] value,
  output logic        value_upd,
  output logic [4:0]  term_idx,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int DW  = $clog2(DIV);
  localparam int TW  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [DW-1:0] TICK_LAST = DW'(DIV - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [4:0]    TERM_LAST = 5'(MAX_TERMS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WAIT,
    S_REQ,
    S_DONE,
    S_ERR
  } state_t;

  state_t        r_state;
  state_t        w_nxt;
  logic [DW-1:0] r_tick;
  logic [TW-1:0] r_tmo;
  logic [15:0]   r_value;
  logic [4:0]    r_term;
  logic          r_upd;
  logic          r_f_rst;
  logic          r_f_en;
  logic          r_busy;
  logic          r_done;
  logic          r_err;

  logic          w_tick_hit;
  logic          w_tmo_hit;
  logic          w_wrap;
  logic          w_cap;
  logic [4:0]    w_term_nx;

  always_comb begin
    w_tick_hit = (r_tick == TICK_LAST);
    w_tmo_hit  = (r_tmo == TMO_LAST);
    w_term_nx  = r_term + 5'd1;
    w_wrap     = (r_term >= 5'd2) && (f_out < r_value);
    // a restart or abort wins over a same-cycle result
    w_cap      = (r_state == S_REQ) && f_valid
                 && !stop && !start && !w_wrap;
  end

  always_comb begin
    w_nxt = r_state;
    if (stop && (r_state != S_IDLE)) begin
      w_nxt = S_IDLE;
    end else if (start && !stop) begin
      w_nxt = S_CLEAR;
    end else begin
      unique case (r_state)
        S_IDLE:  w_nxt = S_IDLE;
        S_CLEAR: w_nxt = S_WAIT;
        S_WAIT: begin
          if (!pause && w_tick_hit) w_nxt = S_REQ;
        end
        S_REQ: begin
          if (f_valid) begin
            if (w_wrap)
              w_nxt = S_ERR;
            else if (w_term_nx == TERM_LAST)
              w_nxt = S_DONE;
            else
              w_nxt = S_WAIT;
          end else if (w_tmo_hit) begin
            w_nxt = S_ERR;
          end
        end
        S_DONE:  w_nxt = S_DONE;
        S_ERR:   w_nxt = S_ERR;
        default: w_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_tick  <= '0;
      r_tmo   <= '0;
      r_value <= '0;
      r_term  <= '0;
      r_upd   <= 1'b0;
      r_f_rst <= 1'b0;
      r_f_en  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_f_rst <= (w_nxt == S_CLEAR);
      r_f_en  <= (w_nxt == S_REQ);
      r_busy  <= (w_nxt == S_CLEAR) || (w_nxt == S_WAIT)
                 || (w_nxt == S_REQ);
      r_done  <= (w_nxt == S_DONE);
      r_err   <= (w_nxt == S_ERR);
      r_upd   <= w_cap;

      if (r_state == S_CLEAR) begin
        r_value <= '0;
        r_term  <= '0;
      end else if (w_cap) begin
        r_value <= f_out;
        r_term  <= w_term_nx;
      end

      // counters restart whenever their state is entered afresh
      if ((r_state == S_WAIT) && (w_nxt == S_WAIT)) begin
        if (!pause) r_tick <= r_tick + 1'b1;
      end else begin
        r_tick <= '0;
      end

      if ((r_state == S_REQ) && (w_nxt == S_REQ))
        r_tmo <= r_tmo + 1'b1;
      else
        r_tmo <= '0;
    end
  end

  assign f_rst     = r_f_rst;
  assign f_en      = r_f_en;
  assign value     = r_value;
  assign value_upd = r_upd;
  assign term_idx  = r_term;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Scoreboard bench for fib_seq_ctrl with a delayed-response datapath model.
// DIV=10, MAX_TERMS=5, TIMEOUT_CYC=8.
module tb_fib_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stop;
  logic        pause;
  logic        f_rst;
  logic        f_en;
  logic        f_valid;
  logic [15:0] f_out;
  logic [15:0] value;
  logic        value_upd;
  logic [4:0]  term_idx;
  logic        busy;
  logic        done;
  logic        err;

  fib_seq_ctrl #(
    .CLK_HZ(100),
    .TICK_HZ(10),
    .MAX_TERMS(5),
    .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .stop(stop),
    .pause(pause),
    .f_rst(f_rst),
    .f_en(f_en),
    .f_valid(f_valid),
    .f_out(f_out),
    .value(value),
    .value_upd(value_upd),
    .term_idx(term_idx),
    .busy(busy),
    .done(done),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_upd = 0;

  logic [15:0] resp_q[$];
  logic [15:0] exp_q[$];
  bit          mdl_on = 0;
  bit          armed  = 0;
  int          dly    = 0;
  bit          prev_en = 0;
  int          m_term = 0;
  logic [15:0] m_last = '0;

  task automatic step();
    logic [15:0] w;
    logic [15:0] v;
    @(posedge clk);
    #1;
    cyc++;
    if (value_upd === 1'b1) begin
      n_upd++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL upd_extra got=%0d want=none", value);
      end else begin
        w = exp_q.pop_front();
        if (value !== w) begin
          bad++;
          $display("FAIL upd_value got=%0d want=%0d", value, w);
        end
      end
    end
    f_valid = 1'b0;
    if (armed) begin
      dly--;
      if (dly == 0) begin
        armed = 0;
        v = (resp_q.size() != 0) ? resp_q.pop_front() : 16'hFFFF;
        f_valid = 1'b1;
        f_out = v;
        if (!(m_term >= 2 && v < m_last)) begin
          exp_q.push_back(v);
          m_term++;
          m_last = v;
        end
      end
    end
    if (mdl_on && f_en === 1'b1 && !prev_en) begin
      armed = 1;
      dly = 2;
    end
    prev_en = (f_en === 1'b1);
  endtask

  task automatic begin_run();
    exp_q.delete();
    armed  = 0;
    m_term = 0;
    m_last = '0;
    mdl_on = 1;
  endtask

  task automatic wait_en(output int t);
    for (int i = 0; i < 60 && f_en !== 1'b1; i++) step();
    t = cyc;
  endtask

  task automatic wait_end();
    for (int i = 0; i < 400 && done !== 1'b1 && err !== 1'b1; i++)
      step();
  endtask

  task automatic test_reset();
    rst = 1; start = 0; stop = 0; pause = 0;
    f_valid = 0; f_out = '0;
    step();
    step();
    total++;
    if ({f_rst, f_en, value_upd, busy, done, err} !== 6'b0 ||
        value !== 16'd0 || term_idx !== 5'd0) begin
      bad++;
      $display("FAIL reset_outs got=%b/%0d/%0d want=0",
        {f_rst, f_en, value_upd, busy, done, err}, value, term_idx);
    end
    rst = 0;
    step();
    total++;
    if (busy !== 1'b0 || f_en !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_rst busy=%b f_en=%b want=0", busy, f_en);
    end
  endtask

  task automatic run_basic(input string tag, input int pause_n,
                           input int want_en);
    int t0;
    int te;
    int u0;
    begin_run();
    resp_q = '{16'd0, 16'd1, 16'd1, 16'd2, 16'd3};
    u0 = n_upd;
    t0 = cyc;
    start = 1;
    step();
    start = 0;
    total++;
    if (f_rst !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL %s_frst got=%b busy=%b want=1", tag, f_rst, busy);
    end
    step();
    total++;
    if (f_rst !== 1'b0) begin
      bad++;
      $display("FAIL %s_frst_len got=%b want=0", tag, f_rst);
    end
    if (pause_n > 0) begin
      pause = 1;
      repeat (pause_n) step();
      pause = 0;
    end
    wait_en(te);
    total++;
    if (f_en !== 1'b1 || te - t0 != want_en) begin
      bad++;
      $display("FAIL %s_first_en got=c%0d want=c%0d", tag, te - t0, want_en);
    end
    wait_end();
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL %s_done got=%b%b%b want=100", tag, done, busy, err);
    end
    total++;
    if (term_idx !== 5'd5 || value !== 16'd3) begin
      bad++;
      $display("FAIL %s_final got=%0d/%0d want=5/3", tag, term_idx, value);
    end
    total++;
    if (n_upd - u0 != 5 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_upd_count got=%0d left=%0d want=5/0",
        tag, n_upd - u0, exp_q.size());
    end
  endtask

  task automatic test_run();
    run_basic("run", 0, 12);
  endtask

  task automatic test_pause();
    run_basic("pause", 7, 19);
  endtask

  task automatic test_timeout();
    int te;
    int n;
    begin_run();
    mdl_on = 0;
    start = 1;
    step();
    start = 0;
    wait_en(te);
    n = 0;
    while (f_en === 1'b1 && n < 40) begin
      n++;
      step();
    end
    total++;
    if (n != 8) begin
      bad++;
      $display("FAIL tmo_len got=%0d want=8", n);
    end
    total++;
    if (err !== 1'b1 || f_en !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL tmo_err err=%b f_en=%b busy=%b want=1/0/0",
        err, f_en, busy);
    end
    repeat (3) step();
    run_basic("restart", 0, 12);
  endtask

  task automatic test_wrap();
    int u0;
    begin_run();
    resp_q = '{16'd0, 16'd1, 16'd5, 16'd2, 16'd9};
    u0 = n_upd;
    start = 1;
    step();
    start = 0;
    wait_end();
    total++;
    if (err !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL wrap_err got=%b/%b want=1/0", err, done);
    end
    total++;
    if (value !== 16'd5) begin
      bad++;
      $display("FAIL wrap_value got=%0d want=5", value);
    end
    total++;
    if (n_upd - u0 != 3 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL wrap_upd got=%0d want=3", n_upd - u0);
    end
  endtask

  task automatic test_stop_start();
    int te;
    begin_run();
    resp_q = '{16'd7};
    start = 1;
    step();
    start = 0;
    for (int i = 0; i < 60 && value_upd !== 1'b1; i++) step();
    mdl_on = 0;
    wait_en(te);
    start = 1;
    stop = 1;
    f_valid = 1;
    f_out = 16'd9;
    step();
    start = 0;
    stop = 0;
    total++;
    if (busy !== 1'b0 || f_en !== 1'b0 || value_upd !== 1'b0) begin
      bad++;
      $display("FAIL ss_idle busy=%b f_en=%b upd=%b want=0",
        busy, f_en, value_upd);
    end
    total++;
    if (value !== 16'd7 || term_idx !== 5'd1) begin
      bad++;
      $display("FAIL ss_hold got=%0d/%0d want=7/1", value, term_idx);
    end
    step();
    total++;
    if (f_rst !== 1'b0 || busy !== 1'b0 || value_upd !== 1'b0) begin
      bad++;
      $display("FAIL ss_stay f_rst=%b busy=%b upd=%b want=0",
        f_rst, busy, value_upd);
    end
  endtask

  task automatic test_rst_mid();
    begin_run();
    resp_q = '{16'h00AA};
    start = 1;
    step();
    start = 0;
    for (int i = 0; i < 60 && value_upd !== 1'b1; i++) step();
    mdl_on = 0;
    repeat (3) step();
    total++;
    if (busy !== 1'b1 || value !== 16'h00AA) begin
      bad++;
      $display("FAIL rm_pre busy=%b value=%0h want=1/aa", busy, value);
    end
    rst = 1;
    step();
    rst = 0;
    exp_q.delete();
    total++;
    if ({f_rst, f_en, value_upd, busy, done, err} !== 6'b0 ||
        value !== 16'd0 || term_idx !== 5'd0) begin
      bad++;
      $display("FAIL rm_outs got=%b/%0d/%0d want=0",
        {f_rst, f_en, value_upd, busy, done, err}, value, term_idx);
    end
    f_valid = 1;
    f_out = 16'h0055;
    step();
    total++;
    if (value_upd !== 1'b0 || value !== 16'd0 || term_idx !== 5'd0) begin
      bad++;
      $display("FAIL rm_idle_valid upd=%b value=%0h idx=%0d want=0",
        value_upd, value, term_idx);
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_pause();
    test_timeout();
    test_wrap();
    test_stop_start();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
